// File: rtl/life_pkg.sv
// Shared types and the cell rule for the Game-of-Life world engine.
package life_pkg;

  localparam logic [7:0] COLOR_LIVE_DEFAULT   = 8'b000_000_00;
  localparam logic [7:0] COLOR_EMPTY_DEFAULT  = 8'b111_111_11;
  localparam logic [7:0] COLOR_BORDER_DEFAULT = 8'b000_000_00;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_INIT,
    FETCH,
    WRITE,
    SWAP
  } engine_state_t;

  function automatic logic life_rule(input logic alive, input logic [3:0] n);
    return (n == 4'd3) || (alive && (n == 4'd2));
  endfunction

endpackage

// File: rtl/life_row_rule.sv
// Combinational next-generation computation for one row from its three source rows.
module life_row_rule
  import life_pkg::*;
#(
  parameter int unsigned WORLD_WIDTH = 64,
  parameter bit          WRAP        = 1'b1
) (
  input  logic [WORLD_WIDTH-1:0] above,
  input  logic [WORLD_WIDTH-1:0] cur,
  input  logic [WORLD_WIDTH-1:0] below,
  output logic [WORLD_WIDTH-1:0] next_row
);

  // One pad cell each side: the wrapped neighbour column, or a dead cell.
  logic [WORLD_WIDTH+1:0] above_ext, cur_ext, below_ext;

  assign above_ext = {WRAP ? above[0] : 1'b0, above, WRAP ? above[WORLD_WIDTH-1] : 1'b0};
  assign cur_ext   = {WRAP ? cur[0]   : 1'b0, cur,   WRAP ? cur[WORLD_WIDTH-1]   : 1'b0};
  assign below_ext = {WRAP ? below[0] : 1'b0, below, WRAP ? below[WORLD_WIDTH-1] : 1'b0};

  for (genvar c = 0; c < WORLD_WIDTH; c++) begin : g_cell
    logic [3:0] n;
    assign n = 4'(above_ext[c]) + 4'(above_ext[c+1]) + 4'(above_ext[c+2])
             + 4'(cur_ext[c])                        + 4'(cur_ext[c+2])
             + 4'(below_ext[c]) + 4'(below_ext[c+1]) + 4'(below_ext[c+2]);
    assign next_row[c] = life_rule(cur[c], n);
  end

endmodule

// File: rtl/life_world_engine.sv
// Double-buffered Game-of-Life world: CPU/VGA see the front buffer, the engine builds the back buffer.
module life_world_engine
  import life_pkg::*;
#(
  parameter int unsigned WORLD_WIDTH  = 64,
  parameter int unsigned WORLD_HEIGHT = 48,
  parameter int unsigned CELL_PIXELS  = 10,
  parameter bit          WRAP         = 1'b1,
  parameter logic [7:0]  COLOR_LIVE   = COLOR_LIVE_DEFAULT,
  parameter logic [7:0]  COLOR_EMPTY  = COLOR_EMPTY_DEFAULT,
  parameter logic [7:0]  COLOR_BORDER = COLOR_BORDER_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cell_write,
  input  logic [$clog2(WORLD_HEIGHT)+$clog2(WORLD_WIDTH/32)-1:0] cell_address,
  input  logic [31:0] cell_data_in,
  output logic [31:0] cell_data_out,
  input  logic        swap_request,
  input  logic        step_start,
  output logic        step_busy,
  output logic        step_done,
  output logic [15:0] generation,
  input  logic [9:0]  x_position,
  input  logic [8:0]  y_position,
  input  logic        inside_video,
  output logic [7:0]  color
);

  localparam int unsigned W     = WORLD_WIDTH / 32;
  localparam int unsigned WB    = $clog2(W);
  localparam int unsigned RB    = $clog2(WORLD_HEIGHT);
  localparam int unsigned KB    = (W > 1) ? WB : 1;
  localparam int unsigned DEPTH = WORLD_HEIGHT * W;
  localparam int unsigned IW    = $clog2(DEPTH);

  logic [31:0] world0 [DEPTH];
  logic [31:0] world1 [DEPTH];
  logic        world_index;

  engine_state_t state;
  logic [RB-1:0] y;
  logic [KB-1:0] word_k;
  logic [1:0]    phase;

  logic [31:0] above_w [W];
  logic [31:0] cur_w   [W];
  logic [31:0] below_w [W];
  logic [31:0] next_w  [W];
  logic [WORLD_WIDTH-1:0] above, cur, below, next_row;

  for (genvar k = 0; k < W; k++) begin : g_pack
    assign above[k*32 +: 32] = above_w[k];
    assign cur[k*32 +: 32]   = cur_w[k];
    assign below[k*32 +: 32] = below_w[k];
    assign next_w[k]         = next_row[k*32 +: 32];
  end

  life_row_rule #(.WORLD_WIDTH(WORLD_WIDTH), .WRAP(WRAP)) u_row_rule (
    .above    (above),
    .cur      (cur),
    .below    (below),
    .next_row (next_row)
  );

  logic [IW-1:0] cpu_index, eng_index, vga_index, wr_index;
  logic [31:0]   eng_data, vga_word, row_word, wr_data;
  logic          eng_valid, wr_en;
  int            eng_target;
  int unsigned   eng_row, cx, cy;

  // Engine row offset relative to y: -1/0/+1 while priming, +2 while fetching ahead.
  always_comb begin
    cpu_index  = IW'((32'(cell_address) >> WB) * W + (32'(cell_address) & ((32'd1 << WB) - 32'd1)));
    eng_target = (state == FETCH) ? int'(y) + 2 : int'(y) + int'(phase) - 1;
    eng_valid  = 1'b1;
    if (eng_target < 0) begin
      eng_valid  = WRAP;
      eng_target = eng_target + int'(WORLD_HEIGHT);
    end else if (eng_target >= int'(WORLD_HEIGHT)) begin
      eng_valid  = WRAP;
      eng_target = eng_target - int'(WORLD_HEIGHT);
    end
    eng_row   = unsigned'(eng_target);
    eng_index = IW'(eng_row * W + 32'(word_k));
    cx        = 32'(x_position) / CELL_PIXELS;
    cy        = 32'(y_position) / CELL_PIXELS;
    vga_index = IW'(cy * W + (cx >> 5));
  end

  assign cell_data_out = world_index ? world1[cpu_index] : world0[cpu_index];
  assign eng_data      = world_index ? world1[eng_index] : world0[eng_index];
  assign vga_word      = world_index ? world1[vga_index] : world0[vga_index];
  assign row_word      = eng_valid ? eng_data : '0;

  always_comb begin
    wr_en    = 1'b0;
    wr_index = cpu_index;
    wr_data  = cell_data_in;
    if (state == WRITE) begin
      wr_en    = 1'b1;
      wr_index = IW'(32'(y) * W + 32'(word_k));
      wr_data  = next_w[word_k];
    end else if (state == IDLE && cell_write) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      if (world_index) world0[wr_index] <= wr_data;
      else             world1[wr_index] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      world_index <= 1'b0;
      step_busy   <= 1'b0;
      step_done   <= 1'b0;
      generation  <= '0;
      y           <= '0;
      word_k      <= '0;
      phase       <= '0;
      above_w     <= '{default: '0};
      cur_w       <= '{default: '0};
      below_w     <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          step_done <= 1'b0;
          if (step_start) begin
            state     <= FETCH_INIT;
            step_busy <= 1'b1;
            y         <= '0;
            word_k    <= '0;
            phase     <= '0;
          end else if (swap_request) begin
            world_index <= ~world_index;
            generation  <= generation + 16'd1;
          end
        end
        FETCH_INIT: begin
          case (phase)
            2'd0:    above_w[word_k] <= row_word;
            2'd1:    cur_w[word_k]   <= row_word;
            default: below_w[word_k] <= row_word;
          endcase
          if (word_k == KB'(W - 1)) begin
            word_k <= '0;
            if (phase == 2'd2) state <= WRITE;
            else               phase <= phase + 2'd1;
          end else begin
            word_k <= word_k + KB'(1);
          end
        end
        WRITE: begin
          if (word_k == KB'(W - 1)) begin
            word_k <= '0;
            if (y == RB'(WORLD_HEIGHT - 1)) begin
              // Swap effects are registered on entry so they coincide with the SWAP cycle.
              state       <= SWAP;
              world_index <= ~world_index;
              generation  <= generation + 16'd1;
              step_done   <= 1'b1;
            end else begin
              above_w <= cur_w;
              cur_w   <= below_w;
              state   <= FETCH;
            end
          end else begin
            word_k <= word_k + KB'(1);
          end
        end
        FETCH: begin
          below_w[word_k] <= row_word;
          if (word_k == KB'(W - 1)) begin
            word_k <= '0;
            y      <= y + RB'(1);
            state  <= WRITE;
          end else begin
            word_k <= word_k + KB'(1);
          end
        end
        SWAP: begin
          step_done <= 1'b0;
          step_busy <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    if (!inside_video)
      color = 8'h00;
    else if (cx >= WORLD_WIDTH || cy >= WORLD_HEIGHT)
      color = COLOR_BORDER;
    else
      color = vga_word[cx[4:0]] ? COLOR_LIVE : COLOR_EMPTY;
  end

endmodule

// File: tb/tb_life_world_engine.sv
// Directed bench: a bounded world (WRAP=0) and a toroidal world (WRAP=1) driven in lockstep.
module tb_life_world_engine;

  localparam int DEPTH = 96;
  localparam int WW    = 2;

  logic        clock = 1'b0, reset = 1'b1;
  logic        cell_write = 1'b0, swap_request = 1'b0, step_start = 1'b0, inside_video = 1'b0;
  logic [6:0]  cell_address = '0;
  logic [31:0] cell_data_in = '0;
  logic [9:0]  x_position = '0;
  logic [8:0]  y_position = '0;

  logic [31:0] dout_a, dout_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [15:0] gen_a, gen_b;
  logic [7:0]  color_a, color_b;

  int checks = 0;
  int errors = 0;
  int cycles;
  logic [31:0] image [DEPTH];

  always #5 clock = ~clock;

  life_world_engine #(.WRAP(1'b0)) u_dut_a (
    .clock(clock), .reset(reset), .cell_write(cell_write), .cell_address(cell_address),
    .cell_data_in(cell_data_in), .cell_data_out(dout_a), .swap_request(swap_request),
    .step_start(step_start), .step_busy(busy_a), .step_done(done_a), .generation(gen_a),
    .x_position(x_position), .y_position(y_position), .inside_video(inside_video), .color(color_a)
  );

  life_world_engine #(.WRAP(1'b1), .COLOR_LIVE(8'h1C), .COLOR_BORDER(8'hE0)) u_dut_b (
    .clock(clock), .reset(reset), .cell_write(cell_write), .cell_address(cell_address),
    .cell_data_in(cell_data_in), .cell_data_out(dout_b), .swap_request(swap_request),
    .step_start(step_start), .step_busy(busy_b), .step_done(done_b), .generation(gen_b),
    .x_position(x_position), .y_position(y_position), .inside_video(inside_video), .color(color_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_image();
    for (int i = 0; i < DEPTH; i++) image[7'(i)] = '0;
  endtask

  task automatic set_cell(input int row, input int col);
    logic [6:0]  idx;
    logic [31:0] w;
    idx = 7'(row * WW + col / 32);
    w = image[idx] | (32'd1 << (col % 32));
    image[idx] = w;
  endtask

  task automatic load_image_and_swap();
    for (int i = 0; i < DEPTH; i++) begin
      cell_write   = 1'b1;
      cell_address = 7'(i);
      cell_data_in = image[7'(i)];
      tick();
    end
    cell_write   = 1'b0;
    swap_request = 1'b1;
    tick();
    swap_request = 1'b0;
  endtask

  task automatic expect_word(input string tag, input int row, input int word,
                             input logic [31:0] exp_a, input logic [31:0] exp_b, input bit use_a);
    cell_address = 7'(row * WW + word);
    #1;
    if (use_a) check({tag, "/a"}, dout_a, exp_a);
    check({tag, "/b"}, dout_b, exp_b);
  endtask

  task automatic run_step(output int n);
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    n = 1;
    while (!done_a && n < 1000) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("reset_busy_a", 32'(busy_a), 32'd0);
    check("reset_busy_b", 32'(busy_b), 32'd0);
    check("reset_done_a", 32'(done_a), 32'd0);
    check("reset_gen_a", 32'(gen_a), 32'd0);
    check("reset_gen_b", 32'(gen_b), 32'd0);
    reset = 1'b0;
    tick();

    // Plain swap from IDLE: generation advances, no step_done.
    clear_image();
    load_image_and_swap();
    check("swap_gen_a", 32'(gen_a), 32'd1);
    check("swap_gen_b", 32'(gen_b), 32'd1);
    check("swap_done_a", 32'(done_a), 32'd0);
    check("swap_busy_a", 32'(busy_a), 32'd0);

    // Blinker mid-world plus a vertical blinker on column 0.
    clear_image();
    set_cell(10, 5); set_cell(11, 5); set_cell(12, 5);
    set_cell(20, 0); set_cell(21, 0); set_cell(22, 0);
    load_image_and_swap();
    check("load_gen_a", 32'(gen_a), 32'd2);
    expect_word("load_r11", 11, 0, 32'h20, 32'h20, 1'b1);
    expect_word("load_r21", 21, 0, 32'h1, 32'h1, 1'b1);

    // step_start and swap_request together; a CPU write to row 0 late in the step is dropped.
    step_start   = 1'b1;
    swap_request = 1'b1;
    tick();
    step_start   = 1'b0;
    swap_request = 1'b0;
    cycles = 1;
    check("start_busy_a", 32'(busy_a), 32'd1);
    check("start_gen_a", 32'(gen_a), 32'd2);
    while (!done_a && cycles < 1000) begin
      if (cycles == 150) begin
        cell_write   = 1'b1;
        cell_address = 7'd0;
        cell_data_in = 32'hDEADBEEF;
      end
      tick();
      cell_write = 1'b0;
      cycles++;
      if (cycles == 160) begin
        cell_address = 7'd0;
        #1;
        check("busy_front_r0", dout_a, 32'h0);
      end
    end
    check("step_cycles", 32'(cycles), 32'd197);
    check("step_gen_a", 32'(gen_a), 32'd3);
    check("step_gen_b", 32'(gen_b), 32'd3);
    check("step_done_b", 32'(done_b), 32'd1);
    check("step_busy_swap", 32'(busy_a), 32'd1);
    tick();
    check("after_done_a", 32'(done_a), 32'd0);
    check("after_busy_a", 32'(busy_a), 32'd0);
    expect_word("blk_r10", 10, 0, 32'h0, 32'h0, 1'b1);
    expect_word("blk_r11", 11, 0, 32'h70, 32'h70, 1'b1);
    expect_word("blk_r12", 12, 0, 32'h0, 32'h0, 1'b1);
    expect_word("blk_r11w1", 11, 1, 32'h0, 32'h0, 1'b1);
    expect_word("edge_r20", 20, 0, 32'h0, 32'h0, 1'b1);
    expect_word("edge_r21", 21, 0, 32'h3, 32'h3, 1'b1);
    expect_word("edge_r21w1", 21, 1, 32'h0, 32'h80000000, 1'b1);
    expect_word("edge_r22", 22, 0, 32'h0, 32'h0, 1'b1);
    expect_word("dropped_r0", 0, 0, 32'h0, 32'h0, 1'b1);

    // Glider straddling the bottom-right corner; four generations shift it by (+1,+1).
    clear_image();
    set_cell(46, 63); set_cell(47, 0);
    set_cell(0, 62); set_cell(0, 63); set_cell(0, 0);
    load_image_and_swap();
    for (int s = 0; s < 4; s++) run_step(cycles);
    check("glider_gen_b", 32'(gen_b), 32'd8);
    expect_word("gl_r46w0", 46, 0, 32'h0, 32'h0, 1'b0);
    expect_word("gl_r46w1", 46, 1, 32'h0, 32'h0, 1'b0);
    expect_word("gl_r47w0", 47, 0, 32'h0, 32'h1, 1'b0);
    expect_word("gl_r47w1", 47, 1, 32'h0, 32'h0, 1'b0);
    expect_word("gl_r0w0", 0, 0, 32'h0, 32'h2, 1'b0);
    expect_word("gl_r0w1", 0, 1, 32'h0, 32'h0, 1'b0);
    expect_word("gl_r1w0", 1, 0, 32'h0, 32'h3, 1'b0);
    expect_word("gl_r1w1", 1, 1, 32'h0, 32'h80000000, 1'b0);

    // Reset 50 cycles into a step.
    step_start = 1'b1;
    tick();
    step_start = 1'b0;
    cycles = 1;
    while (cycles < 50) begin
      tick();
      cycles++;
    end
    check("mid_busy_before", 32'(busy_b), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy_a", 32'(busy_a), 32'd0);
    check("abort_busy_b", 32'(busy_b), 32'd0);
    check("abort_gen_b", 32'(gen_b), 32'd0);
    expect_word("abort_r0w0", 0, 0, 32'h0, 32'h2, 1'b0);
    expect_word("abort_r1w1", 1, 1, 32'h0, 32'h80000000, 1'b0);
    tick();
    reset = 1'b0;
    tick();

    // VGA mapping with cell (x=3, y=2) live.
    clear_image();
    set_cell(2, 3);
    load_image_and_swap();
    inside_video = 1'b1;
    x_position = 10'd35;  y_position = 9'd25;  #1;
    check("vga_live_a", 32'(color_a), 32'h00);
    check("vga_live_b", 32'(color_b), 32'h1C);
    x_position = 10'd39;  y_position = 9'd29;  #1;
    check("vga_live_edge_b", 32'(color_b), 32'h1C);
    x_position = 10'd40;  y_position = 9'd25;  #1;
    check("vga_empty_a", 32'(color_a), 32'hFF);
    check("vga_empty_b", 32'(color_b), 32'hFF);
    x_position = 10'd29;  #1;
    check("vga_empty_left_b", 32'(color_b), 32'hFF);
    x_position = 10'd645; #1;
    check("vga_border_a", 32'(color_a), 32'h00);
    check("vga_border_b", 32'(color_b), 32'hE0);
    x_position = 10'd35;  y_position = 9'd485; #1;
    check("vga_border_y_b", 32'(color_b), 32'hE0);
    x_position = 10'd40;  y_position = 9'd25;  inside_video = 1'b0; #1;
    check("vga_blank_a", 32'(color_a), 32'h00);
    check("vga_blank_b", 32'(color_b), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
